undo_stack: RTL and testbench

UNDO_STACK -- requirements
Module: undo_stack

---
 rtl/undo_stack_pkg.sv | 20 ++
 rtl/undo_stack_if.sv | 30 +++
 rtl/undo_stack_ram.sv | 34 +++
 rtl/undo_stack.sv | 104 ++++++++++
 tb/tb_undo_stack.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/undo_stack_pkg.sv
// Shared constants for the undo stack: default widths, depth and signal codes.
package undo_stack_pkg;

  localparam int unsigned UNDO_DW    = 16;
  localparam int unsigned UNDO_AW    = 8;
  localparam int unsigned UNDO_DEPTH = 1 << UNDO_AW;

  // Signal codes raised toward the core; SIGCHK reports a sticky undo underflow.
  localparam int unsigned SIG_W   = 5;
  localparam logic [SIG_W-1:0] SIGNONE = 5'd0;
  localparam logic [SIG_W-1:0] SIGILL  = 5'd4;
  localparam logic [SIG_W-1:0] SIGTRAP = 5'd5;
  localparam logic [SIG_W-1:0] SIGCHK  = 5'd7;

  // Signal code the core should take for a given underflow flag.
  function automatic logic [SIG_W-1:0] uflow_sig(input logic uflow);
    return uflow ? SIGCHK : SIGNONE;
  endfunction

endpackage

// File: rtl/undo_stack_if.sv
// Command/result bundle between the reverse-execution core and the undo stack.
interface undo_stack_if
  import undo_stack_pkg::*;
#(
  parameter int unsigned DW = UNDO_DW,
  parameter int unsigned AW = UNDO_AW
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic          peek;
  logic [AW-1:0] peek_off;
  logic          clr_err;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] usp;
  logic [AW:0]   count;
  logic          empty;
  logic          uflow_err;

  modport master (
    output push, push_data, pop, peek, peek_off, clr_err,
    input  rd_data, rd_valid, usp, count, empty, uflow_err
  );

  modport slave (
    input  push, push_data, pop, peek, peek_off, clr_err,
    output rd_data, rd_valid, usp, count, empty, uflow_err
  );
endinterface

// File: rtl/undo_stack_ram.sv
// undo_ram: 2^AW x DW storage, one sync write port, one sync read port.
// The read returns pre-write contents when both ports hit one address.
module undo_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rzero_i,
  output logic [DW-1:0] rdata_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; underflow reads return zero, otherwise hold last value.
  always_ff @(posedge clk) begin
    if (rst_i)      rdata_q <= '0;
    else if (re_i)  rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/undo_stack.sv
// Undo stack for reverse execution: push/pop/peek over a circular 2^AW buffer.
// Optional feature macro: UNDO_UNDERFLOW_TRAP_EN (sticky underflow flag).
module undo_stack
  import undo_stack_pkg::*;
#(
  parameter int unsigned DW = UNDO_DW,
  parameter int unsigned AW = UNDO_AW
) (
  input  logic           clk,
  input  logic           reset,
  undo_stack_if.slave    bus
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] usp_q, usp_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          rd_valid_q, rd_valid_d;
  logic          have_c, uflow_ev_c, replace_c, grow_c, shrink_c;
  logic          we_c, re_c;
  logic [AW-1:0] top_c, waddr_c, raddr_c;

  // Pointer/count next state and RAM port steering.
  always_comb begin
    have_c     = (count_q != '0);
    top_c      = usp_q - AW'(1);
    uflow_ev_c = bus.pop && !have_c;
    replace_c  = bus.push && bus.pop && have_c;
    grow_c     = bus.push && !replace_c;
    shrink_c   = bus.pop && !bus.push && have_c;
    we_c       = bus.push && !reset;
    waddr_c    = replace_c ? top_c : usp_q;
    re_c       = bus.pop || bus.peek;
    raddr_c    = bus.pop ? top_c : AW'(usp_q - bus.peek_off - AW'(1));
    usp_d      = usp_q;
    count_d    = count_q;
    if (grow_c) begin
      usp_d   = usp_q + AW'(1);
      count_d = (count_q == FULL) ? FULL : count_q + CW'(1);
    end else if (shrink_c) begin
      usp_d   = top_c;
      count_d = count_q - CW'(1);
    end
    empty_d    = (count_d == '0);
    rd_valid_d = re_c;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      usp_q      <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      usp_q      <= usp_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  undo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .rst_i   (reset),
    .we_i    (we_c),
    .waddr_i (waddr_c),
    .wdata_i (bus.push_data),
    .re_i    (re_c),
    .raddr_i (raddr_c),
    .rzero_i (uflow_ev_c),
    .rdata_o (bus.rd_data)
  );

`ifdef UNDO_UNDERFLOW_TRAP_EN
  logic uflow_q, uflow_d;

  // Sticky underflow: a new event beats a simultaneous clear.
  always_comb begin
    uflow_d = uflow_q;
    if (uflow_ev_c)       uflow_d = 1'b1;
    else if (bus.clr_err) uflow_d = 1'b0;
  end

  // Underflow flag register.
  always_ff @(posedge clk) begin
    if (reset) uflow_q <= 1'b0;
    else       uflow_q <= uflow_d;
  end

  assign bus.uflow_err = uflow_q;
`else
  logic unused_uflow_c;
  assign unused_uflow_c = bus.clr_err ^ uflow_ev_c;
  assign bus.uflow_err  = 1'b0;
`endif

  assign bus.usp      = usp_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_undo_stack.sv
// Directed bench for undo_stack with a queue-level reference model.
module tb_undo_stack;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  undo_stack_if #(.DW(DW), .AW(AW)) bus ();

  undo_stack #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef UNDO_UNDERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: an ordered list of saved values, oldest first, plus a
  // circular image of the buffer for peeks at stale positions.
  logic [DW-1:0] m_img [DEPTH];
  logic [DW-1:0] m_stack [$];
  int            m_ptr = 0;
  logic [DW-1:0] m_rd = '0;
  bit            m_valid = 1'b0;
  bit            m_uflow = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model update on each rising edge from the inputs applied in that cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_stack.delete();
      m_ptr = 0; m_rd = '0; m_valid = 1'b0; m_uflow = 1'b0;
    end else begin
      bit ev;
      ev = 1'b0;
      m_valid = bus.pop || bus.peek;
      if (bus.pop) begin
        if (m_stack.size() == 0) begin
          ev = 1'b1;
          m_rd = '0;
          if (bus.push) begin
            m_img[m_ptr] = bus.push_data;
            m_stack.push_back(bus.push_data);
            m_ptr = (m_ptr + 1) % DEPTH;
          end
        end else begin
          m_rd = m_stack.pop_back();
          if (bus.push) begin
            m_img[(m_ptr + DEPTH - 1) % DEPTH] = bus.push_data;
            m_stack.push_back(bus.push_data);
          end else begin
            m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
          end
        end
      end else begin
        if (bus.peek) m_rd = m_img[(m_ptr + 2 * DEPTH - int'(bus.peek_off) - 1) % DEPTH];
        if (bus.push) begin
          m_img[m_ptr] = bus.push_data;
          m_stack.push_back(bus.push_data);
          if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
      if (TRAP) begin
        if (ev) m_uflow = 1'b1;
        else if (bus.clr_err) m_uflow = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("usp", 32'(bus.usp), 32'(m_ptr));
      check("count", 32'(bus.count), 32'(m_stack.size()));
      check("empty", 32'(bus.empty), 32'(m_stack.size() == 0));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
      check("rd_data", 32'(bus.rd_data), 32'(m_rd));
      check("uflow_err", 32'(bus.uflow_err), 32'(m_uflow));
    end
  end

  task automatic drive(input logic rst, input logic psh, input logic [DW-1:0] pd,
                       input logic pp, input logic pk, input logic [AW-1:0] off,
                       input logic clr);
    @(negedge clk);
    reset = rst; bus.push = psh; bus.push_data = pd; bus.pop = pp;
    bus.peek = pk; bus.peek_off = off; bus.clr_err = clr;
  endtask

  task automatic idle();       drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic push(input logic [DW-1:0] d); drive(1'b0, 1'b1, d, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic pop();        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0); endtask
  task automatic peek(input logic [AW-1:0] o); drive(1'b0, 1'b0, '0, 1'b0, 1'b1, o, 1'b0); endtask

  initial begin
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0; bus.peek = 1'b0;
    bus.peek_off = '0; bus.clr_err = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    chk_en = 1'b1;
    check("rst_usp", 32'(bus.usp), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd", 32'(bus.rd_data), 32'd0);

    // Basic LIFO order
    push(16'h1111); push(16'h2222); push(16'h3333);
    pop();
    check("lifo_usp", 32'(bus.usp), 32'd3);
    check("lifo_count", 32'(bus.count), 32'd3);
    pop();
    check("pop1", 32'(bus.rd_data), 32'h3333);
    pop();
    check("pop2", 32'(bus.rd_data), 32'h2222);
    idle();
    check("pop3", 32'(bus.rd_data), 32'h1111);
    check("pop3_empty", 32'(bus.empty), 32'd1);
    idle();
    check("hold_valid", 32'(bus.rd_valid), 32'd0);
    check("hold_rd", 32'(bus.rd_data), 32'h1111);

    // Underflow
    pop(); idle();
    check("uf_rd", 32'(bus.rd_data), 32'd0);
    check("uf_valid", 32'(bus.rd_valid), 32'd1);
    check("uf_usp", 32'(bus.usp), 32'd0);
    check("uf_flag", 32'(bus.uflow_err), 32'(TRAP));
    idle();
    check("uf_sticky", 32'(bus.uflow_err), 32'(TRAP));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    idle();
    check("uf_vs_clr", 32'(bus.uflow_err), 32'(TRAP));
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle();
    check("uf_clr", 32'(bus.uflow_err), 32'd0);

    // Replace top
    push(16'h0005); push(16'h0007);
    drive(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, '0, 1'b0);
    idle();
    check("rep_rd", 32'(bus.rd_data), 32'h0007);
    check("rep_count", 32'(bus.count), 32'd2);
    pop(); idle();
    check("rep_pop", 32'(bus.rd_data), 32'h0009);
    pop(); idle();
    check("rep_pop2", 32'(bus.rd_data), 32'h0005);

    // Peek, peek with pop, peek with push
    push(16'h0010); push(16'h0020); push(16'h0030);
    peek(8'd2); idle();
    check("peek_rd", 32'(bus.rd_data), 32'h0010);
    check("peek_usp", 32'(bus.usp), 32'd3);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'd0, 1'b0);
    idle();
    check("peekpop_rd", 32'(bus.rd_data), 32'h0030);
    check("peekpop_cnt", 32'(bus.count), 32'd2);
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 8'd0, 1'b0);
    idle();
    check("peekpush_rd", 32'(bus.rd_data), 32'h0020);
    check("peekpush_cnt", 32'(bus.count), 32'd3);
    pop(); pop(); pop(); idle();
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Fill past capacity
    for (int i = 0; i < 256; i++) push(16'hA000 + 16'(i));
    push(16'hBEEF);
    idle();
    check("full_usp", 32'(bus.usp), 32'd1);
    check("full_count", 32'(bus.count), 32'd256);
    peek(8'd0); peek(8'd255);
    check("full_peek0", 32'(bus.rd_data), 32'hBEEF);
    idle();
    check("full_peek255", 32'(bus.rd_data), 32'hA001);
    pop(); pop(); idle();
    check("wrap_pop", 32'(bus.rd_data), 32'hA0FF);
    check("wrap_usp", 32'(bus.usp), 32'd255);

    // Reset with pending pop
    push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    check("rstpop_valid", 32'(bus.rd_valid), 32'd0);
    check("rstpop_usp", 32'(bus.usp), 32'd0);
    check("rstpop_count", 32'(bus.count), 32'd0);

    // Push with pop on empty
    drive(1'b0, 1'b1, 16'h0077, 1'b1, 1'b0, '0, 1'b0);
    idle();
    check("pp_empty_rd", 32'(bus.rd_data), 32'd0);
    check("pp_empty_cnt", 32'(bus.count), 32'd1);
    check("pp_empty_uf", 32'(bus.uflow_err), 32'(TRAP));
    pop(); idle();
    check("pp_empty_pop", 32'(bus.rd_data), 32'h0077);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
